// File: rtl/spi_sram_pkg.sv
// Shared opcodes, FSM/mode types and mode-register decode for the clk-domain SPI SRAM slave.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, RDMR, WRMR, IGNORE} state_t;
  typedef enum logic [1:0] {MODE_BYTE, MODE_SEQ, MODE_PAGE} mode_t;

  // Encoding 2'b11 is reserved and behaves as sequential.
  function automatic mode_t decode_mode(input logic [1:0] bits);
    mode_t m;
    case (bits)
      2'b00:   m = MODE_BYTE;
      2'b10:   m = MODE_PAGE;
      default: m = MODE_SEQ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spi_sram_if.sv
// SPI pad-side bundle between an SPI master and the SRAM slave.
interface spi_sram_if;
  logic sck;
  logic cs_n;
  logic si;
  logic so;
  logic so_oe;
  logic busy;

  modport master (output sck, output cs_n, output si, input so, input so_oe, input busy);
  modport slave  (input sck, input cs_n, input si, output so, output so_oe, output busy);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one edge-detected input plus WIDTH level-only inputs.
module spi_sync_edge #(
  parameter int              SYNC_STAGES = 2,
  parameter int              WIDTH       = 1,
  parameter logic            E_RESET     = 1'b0,
  parameter logic [WIDTH-1:0] D_RESET    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0][WIDTH:0] sync_q, sync_d;
  logic                            prev_q, prev_d;

  // Next value of every synchroniser chain and of the edge-history flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {d, e}};
    prev_d = sync_q[SYNC_STAGES-1][0];
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{{D_RESET, E_RESET}}};
      prev_q <= E_RESET;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1][WIDTH:1];
  assign rise = sync_q[SYNC_STAGES-1][0] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1][0] & prev_q;

endmodule

// File: rtl/spi_sram_slave_sync.sv
// 23LC512-style SPI mode-0 SRAM slave, oversampling SCK/CS_n/SI on clk; READ/WRITE/RDMR/WRMR.
module spi_sram_slave_sync
  import spi_sram_pkg::*;
#(
  parameter int         ADDR_BITS    = 16,
  parameter int         MEM_DEPTH    = 65536,
  parameter int         PAGE_BYTES   = 32,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [1:0] DEFAULT_MODE = 2'b01
) (
  input logic        clk,
  input logic        rst_n,
  spi_sram_if.slave  bus
);

  localparam int                   MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(PAGE_BYTES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return 32'(a) < 32'(MEM_DEPTH);
  endfunction

  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a, input mode_t m);
    logic [ADDR_BITS-1:0] n;
    case (m)
      MODE_PAGE: n = (a & ~PAGE_MASK) | ((a + ADDR_BITS'(1)) & PAGE_MASK);
      default:   n = (a == LAST_ADDR) ? {ADDR_BITS{1'b0}} : a + ADDR_BITS'(1);
    endcase
    return n;
  endfunction

  logic                 sck_rise_s, sck_fall_s, cs_sync_s, si_sync_s;
  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic [6:0]           shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           mode_q, mode_d;
  logic                 rd_op_q, rd_op_d;
  logic                 oor_q, oor_d;
  logic                 so_q, so_d;
  logic                 so_oe_q, so_oe_d;
  logic                 busy_q, busy_d;
  logic [7:0]           byte_in_s, load_s;
  logic [ADDR_BITS-1:0] addr_in_s;
  mode_t                mode_s;
  logic                 mem_we_s, mem_re_s;
  logic [MEM_AW-1:0]    mem_idx_s;
  logic [7:0]           mem [MEM_DEPTH];
  logic [7:0]           mem_dout_q;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (2),
    .E_RESET     (1'b0),
    .D_RESET     (2'b01)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .e     (bus.sck),
    .d     ({bus.si, bus.cs_n}),
    .q     ({si_sync_s, cs_sync_s}),
    .rise  (sck_rise_s),
    .fall  (sck_fall_s)
  );

  assign byte_in_s = {shift_q, si_sync_s};
  assign addr_in_s = {addr_q[ADDR_BITS-2:0], si_sync_s};
  assign mode_s    = decode_mode(mode_q[7:6]);
  assign load_s    = (state_q == RDMR) ? mode_q : (oor_q ? 8'h00 : mem_dout_q);

  // Protocol FSM: bit collection on sck rise, MISO shifting on sck fall, cs_n release wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mode_d    = mode_q;
    rd_op_d   = rd_op_q;
    oor_d     = oor_q;
    so_d      = so_q;
    so_oe_d   = so_oe_q;
    mem_we_s  = 1'b0;
    mem_re_s  = 1'b0;
    mem_idx_s = MEM_AW'(addr_q);
    if (cs_sync_s) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      fcnt_d  = 3'd0;
      so_d    = 1'b0;
      so_oe_d = 1'b0;
    end else if (sck_rise_s) begin
      shift_d = byte_in_s[6:0];
      case (state_q)
        IDLE: begin
          state_d = CMD;
          shift_d = {6'd0, si_sync_s};
          cnt_d   = 5'd1;
        end
        CMD: begin
          if (cnt_q == 5'd7) begin
            cnt_d = 5'd0;
            case (byte_in_s)
              OP_READ:  begin state_d = ADDR; rd_op_d = 1'b1; end
              OP_WRITE: begin state_d = ADDR; rd_op_d = 1'b0; end
              OP_RDMR:  begin state_d = RDMR; fcnt_d = 3'd0; end
              OP_WRMR:  state_d = WRMR;
              default:  state_d = IGNORE;
            endcase
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        ADDR: begin
          addr_d = addr_in_s;
          if (cnt_q == 5'(ADDR_BITS - 1)) begin
            cnt_d  = 5'd0;
            fcnt_d = 3'd0;
            if (rd_op_q) begin
              state_d   = RD;
              mem_re_s  = 1'b1;
              mem_idx_s = MEM_AW'(addr_in_s);
              oor_d     = ~in_range(addr_in_s);
            end else begin
              state_d = WR;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        RD: begin
          if (cnt_q == 5'd7) begin
            cnt_d = 5'd0;
            if (mode_s == MODE_BYTE) begin
              state_d = IGNORE;
              so_d    = 1'b0;
              so_oe_d = 1'b0;
            end else begin
              addr_d    = next_addr(addr_q, mode_s);
              mem_re_s  = 1'b1;
              mem_idx_s = MEM_AW'(next_addr(addr_q, mode_s));
              oor_d     = ~in_range(next_addr(addr_q, mode_s));
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        WR: begin
          if (cnt_q == 5'd7) begin
            cnt_d    = 5'd0;
            mem_we_s = rst_n & in_range(addr_q);
            if (mode_s == MODE_BYTE) begin
              state_d = IGNORE;
            end else begin
              addr_d = next_addr(addr_q, mode_s);
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        WRMR: begin
          if (cnt_q == 5'd7) begin
            cnt_d   = 5'd0;
            mode_d  = byte_in_s;
            state_d = IGNORE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (sck_fall_s && (state_q == RD || state_q == RDMR)) begin
      so_oe_d = 1'b1;
      fcnt_d  = fcnt_q + 3'd1;
      if (fcnt_q == 3'd0) begin
        so_d   = load_s[7];
        data_d = {load_s[6:0], 1'b0};
      end else begin
        so_d   = data_q[7];
        data_d = {data_q[6:0], 1'b0};
      end
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // FSM, datapath and output registers; memory contents are not part of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      fcnt_q  <= 3'd0;
      shift_q <= 7'd0;
      addr_q  <= {ADDR_BITS{1'b0}};
      data_q  <= 8'd0;
      mode_q  <= {DEFAULT_MODE, 6'b000000};
      rd_op_q <= 1'b0;
      oor_q   <= 1'b0;
      so_q    <= 1'b0;
      so_oe_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rd_op_q <= rd_op_d;
      oor_q   <= oor_d;
      so_q    <= so_d;
      so_oe_q <= so_oe_d;
      busy_q  <= busy_d;
    end
  end

  // Single-port byte array, one access per clk, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_idx_s] <= byte_in_s;
    end else if (mem_re_s) begin
      mem_dout_q <= mem[mem_idx_s];
    end
  end

  assign bus.so    = so_q;
  assign bus.so_oe = so_oe_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_spi_sram_slave_sync.sv
// Scoreboard bench for spi_sram_slave_sync: SPI mode-0 master at clk/8, MEM_DEPTH=1024.
module tb_spi_sram_slave_sync;
  import spi_sram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_q[$];

  spi_sram_if bif();

  spi_sram_slave_sync #(
    .ADDR_BITS    (16),
    .MEM_DEPTH    (1024),
    .PAGE_BYTES   (32),
    .SYNC_STAGES  (2),
    .DEFAULT_MODE (2'b01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Shift nb bits of tx MSB-first; so is sampled just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    rx = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < nb; i++) begin
      bif.si = tx[7-i];
      repeat (4) @(negedge clk);
      rx[7-i] = bif.so;
      oe_any  = oe_any | bif.so_oe;
      oe_all  = oe_all & bif.so_oe;
      bif.sck = 1'b1;
      repeat (4) @(negedge clk);
      bif.sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    bif.cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (4) @(negedge clk);
    bif.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_oe", bif.so_oe, 1'b0);
    check("idle_busy", bif.busy, 1'b0);
  endtask

  // Byte sent while MISO must stay disabled.
  task automatic send_quiet(input string tag, input logic [7:0] tx);
    logic [7:0] rx; logic any, all;
    spi_bits(tx, 8, rx, any, all);
    check(tag, any, 1'b0);
  endtask

  // Receive one data byte and compare against the scoreboard head.
  task automatic recv_exp(input string tag);
    logic [7:0] rx; logic any, all; logic [7:0] exp;
    spi_bits(8'h00, 8, rx, any, all);
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check(tag, rx, exp);
      check({tag, "_oe"}, all, 1'b1);
    end
  endtask

  task automatic spi_wr(input logic [15:0] a, input int n, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    cs_lo();
    send_quiet("wr_cmd_oe", OP_WRITE);
    send_quiet("wr_ah_oe", a[15:8]);
    send_quiet("wr_al_oe", a[7:0]);
    for (int k = 0; k < n; k++) send_quiet("wr_dat_oe", d[k]);
    cs_hi();
  endtask

  task automatic spi_rd(input logic [15:0] a, input int n);
    cs_lo();
    send_quiet("rd_cmd_oe", OP_READ);
    send_quiet("rd_ah_oe", a[15:8]);
    send_quiet("rd_al_oe", a[7:0]);
    for (int k = 0; k < n; k++) recv_exp("rd_data");
    cs_hi();
  endtask

  task automatic spi_wrmr(input logic [7:0] m);
    cs_lo();
    send_quiet("wrmr_cmd_oe", OP_WRMR);
    send_quiet("wrmr_dat_oe", m);
    cs_hi();
  endtask

  task automatic spi_rdmr(input int n);
    cs_lo();
    send_quiet("rdmr_cmd_oe", OP_RDMR);
    for (int k = 0; k < n; k++) recv_exp("rdmr");
    cs_hi();
  endtask

  initial begin
    logic [7:0] rx; logic any, all;
    rst_n = 1'b0; bif.sck = 1'b0; bif.cs_n = 1'b1; bif.si = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_so", bif.so, 1'b0);
    check("rst_oe", bif.so_oe, 1'b0);
    check("rst_busy", bif.busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h40);
    spi_rdmr(1);

    // 1: sequential write / read
    spi_wr(16'h0010, 3, 8'hA5, 8'h5A, 8'h3C);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
    spi_rd(16'h0010, 3);

    // 2: page wrap, mode readback repeated
    spi_wrmr(8'h80);
    spi_wr(16'h001F, 3, 8'h11, 8'h22, 8'h33);
    exp_q.push_back(8'h80); exp_q.push_back(8'h80);
    spi_rdmr(2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    spi_rd(16'h001F, 3);

    // 3: rollover at MEM_DEPTH-1 and out-of-range
    spi_wrmr(8'h40);
    spi_wr(16'h03FF, 2, 8'h77, 8'h88, 8'h00);
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    spi_rd(16'h03FF, 2);
    exp_q.push_back(8'h88); exp_q.push_back(8'h33);
    spi_rd(16'h0000, 2);
    exp_q.push_back(8'h00);
    spi_rd(16'h0400, 1);
    spi_wr(16'h0400, 1, 8'h99, 8'h00, 8'h00);
    exp_q.push_back(8'h88);
    spi_rd(16'h0000, 1);

    // 4: byte mode stops after one byte
    spi_wrmr(8'h00);
    exp_q.push_back(8'hA5);
    cs_lo();
    send_quiet("bm_cmd_oe", OP_READ);
    send_quiet("bm_ah_oe", 8'h00);
    send_quiet("bm_al_oe", 8'h10);
    recv_exp("bm_data");
    spi_bits(8'h00, 8, rx, any, all);
    check("bm_second_oe", any, 1'b0);
    check("bm_second_so", rx, 8'h00);
    cs_hi();

    // 5: partial write discarded on cs_n rise
    spi_wr(16'h0020, 1, 8'hEE, 8'h00, 8'h00);
    cs_lo();
    send_quiet("ab_cmd_oe", OP_WRITE);
    send_quiet("ab_ah_oe", 8'h00);
    send_quiet("ab_al_oe", 8'h20);
    spi_bits(8'h50, 4, rx, any, all);
    check("ab_busy_mid", bif.busy, 1'b1);
    bif.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check("ab_busy_idle", bif.busy, 1'b0);
    check("ab_oe_idle", bif.so_oe, 1'b0);
    repeat (4) @(negedge clk);
    exp_q.push_back(8'hEE);
    spi_rd(16'h0020, 1);

    // 6: reset mid-read restores default mode; illegal opcode is inert
    spi_wrmr(8'h40);
    cs_lo();
    send_quiet("rr_cmd_oe", OP_READ);
    send_quiet("rr_ah_oe", 8'h00);
    send_quiet("rr_al_oe", 8'h10);
    spi_bits(8'h00, 4, rx, any, all);
    check("rr_oe_before", all, 1'b1);
    check("rr_bits", rx[7:4], 4'hA);
    spi_wrmr_dummy: begin end
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_oe_after", bif.so_oe, 1'b0);
    check("rr_so_after", bif.so, 1'b0);
    check("rr_busy_after", bif.busy, 1'b0);
    bif.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h40);
    spi_rdmr(1);
    cs_lo();
    send_quiet("ill_cmd_oe", 8'hFF);
    send_quiet("ill_b0_oe", 8'h02);
    send_quiet("ill_b1_oe", 8'h00);
    send_quiet("ill_b2_oe", 8'h10);
    send_quiet("ill_b3_oe", 8'h99);
    cs_hi();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
    spi_rd(16'h0010, 3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
